// File: rtl/game_pkg.sv
// Shared types and constants for the game flow controller.
//   game_state_t : 2-bit game state, encoding is also the value seen on the state port
//   START_KEY_DEF: default keycode that starts or restarts a game
//   SCORE_W      : score width in bits
package game_pkg;

  typedef enum logic [1:0] {
    ATTRACT  = 2'b00,
    RUN      = 2'b01,
    CRASH    = 2'b10,
    GAMEOVER = 2'b11
  } game_state_t;

  localparam logic [7:0] START_KEY_DEF = 8'h15;
  localparam int         SCORE_W       = 16;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game flow controller and its neighbours
// (collision detector, keyboard interface, sprite/motion modules).
//   frame_tick, collision, keycode             : into the controller
//   collision_clr, game_run, npc_respawn,
//   crash_blink, lives, score, state           : out of the controller
// slave  = controller side, master = environment side.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic               frame_tick;
  logic               collision;
  logic [7:0]         keycode;
  logic               collision_clr;
  logic               game_run;
  logic               npc_respawn;
  logic               crash_blink;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  game_state_t        state;

  modport slave (
    input  frame_tick, collision, keycode,
    output collision_clr, game_run, npc_respawn, crash_blink, lives, score, state
  );

  modport master (
    output frame_tick, collision, keycode,
    input  collision_clr, game_run, npc_respawn, crash_blink, lives, score, state
  );

endinterface

// File: rtl/frame_divider.sv
// Modulo-N counter advanced by qualified frame ticks.
//   clk    : system clock
//   rst_i  : synchronous active-high reset
//   clr_i  : synchronous clear of the count
//   en_i   : counting enable (count holds while low)
//   tick_i : frame tick
//   wrap_o : high in the cycle whose tick takes the count from N-1 back to 0
module frame_divider #(
  parameter int N = 8
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic tick_i,
  output logic wrap_o
);

  // N = 1 still needs a one-bit counter; it simply wraps on every tick.
  localparam int           W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         step;

  assign step   = en_i & tick_i;
  assign wrap_o = step & (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || wrap_o) cnt_d = '0;
    else if (step)       cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: ATTRACT -> RUN -> CRASH -> RUN/GAMEOVER.
// Consumes the sticky collision flag and the USB keycode; drives motion
// enable, NPC respawn pulses, crash blink, lives and a saturating score.
//   clk   : system clock
//   Reset : synchronous active-high reset
//   gf    : controller side of game_flow_ctrl_if (see interface header)
//
//   state    | meaning
//   ATTRACT  | idle after reset, waiting for a start key press
//   RUN      | game in motion, score advances every SCORE_DIV frames
//   CRASH    | motion frozen for CRASH_FRAMES frames, crash_blink flashing
//   GAMEOVER | no lives left, waiting for a start key press
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter logic [7:0] START_KEY    = START_KEY_DEF,
  parameter int         LIVES        = 3,
  parameter int         CRASH_FRAMES = 120,
  parameter int         SCORE_DIV    = 8,
  parameter int         BLINK_PERIOD = 8
) (
  input logic              clk,
  input logic              Reset,
  game_flow_ctrl_if.slave  gf
);

  localparam logic [1:0]         LIVES_INIT = 2'(LIVES);
  localparam int                 BLINK_W    = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

  game_state_t        state_q;
  logic [7:0]         key_q;
  logic [1:0]         lives_q;
  logic [SCORE_W-1:0] score_q;
  logic [BLINK_W-1:0] blink_cnt_q;
  logic               game_run_q;
  logic               npc_respawn_q;
  logic               collision_clr_q;
  logic               crash_blink_q;

  logic start_evt;
  logic idle;
  logic game_start;
  logic run_to_crash;
  logic score_step;
  logic crash_tick;
  logic crash_done;

  // Rising edge of the start key only, so a held key starts one game.
  assign start_evt    = (gf.keycode == START_KEY) && (key_q != START_KEY);
  assign idle         = (state_q == ATTRACT) || (state_q == GAMEOVER);
  assign game_start   = idle && start_evt;
  assign run_to_crash = (state_q == RUN) && gf.collision;
  assign crash_tick   = (state_q == CRASH) && gf.frame_tick;

  // Collision masks the score divider so a coincident tick earns nothing.
  frame_divider #(.N(SCORE_DIV)) u_score_div (
    .clk    (clk),
    .rst_i  (Reset),
    .clr_i  (game_start),
    .en_i   ((state_q == RUN) && !gf.collision),
    .tick_i (gf.frame_tick),
    .wrap_o (score_step)
  );

  frame_divider #(.N(CRASH_FRAMES)) u_crash_tmr (
    .clk    (clk),
    .rst_i  (Reset),
    .clr_i  (run_to_crash),
    .en_i   (state_q == CRASH),
    .tick_i (gf.frame_tick),
    .wrap_o (crash_done)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q         <= ATTRACT;
      key_q           <= '0;
      lives_q         <= LIVES_INIT;
      score_q         <= '0;
      blink_cnt_q     <= '0;
      game_run_q      <= 1'b0;
      npc_respawn_q   <= 1'b0;
      collision_clr_q <= 1'b0;
      crash_blink_q   <= 1'b0;
    end else begin
      key_q           <= gf.keycode;
      npc_respawn_q   <= 1'b0;
      collision_clr_q <= 1'b0;

      if (score_step && (score_q != '1)) score_q <= score_q + 1'b1;

      unique case (state_q)
        ATTRACT, GAMEOVER: begin
          // Flush any stale flag so it cannot crash the next game at once.
          collision_clr_q <= gf.collision;
          if (start_evt) begin
            state_q       <= RUN;
            lives_q       <= LIVES_INIT;
            score_q       <= '0;
            npc_respawn_q <= 1'b1;
            game_run_q    <= 1'b1;
          end
        end

        RUN: begin
          if (gf.collision) begin
            state_q         <= CRASH;
            lives_q         <= lives_q - 1'b1;
            collision_clr_q <= 1'b1;
            crash_blink_q   <= 1'b1;
            blink_cnt_q     <= '0;
            game_run_q      <= 1'b0;
          end
        end

        CRASH: begin
          if (crash_done) begin
            crash_blink_q <= 1'b0;
            if (lives_q == 2'd0) begin
              state_q <= GAMEOVER;
            end else begin
              state_q       <= RUN;
              npc_respawn_q <= 1'b1;
              game_run_q    <= 1'b1;
            end
          end else if (crash_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
              blink_cnt_q   <= '0;
              crash_blink_q <= ~crash_blink_q;
            end else begin
              blink_cnt_q <= blink_cnt_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign gf.state         = state_q;
  assign gf.lives         = lives_q;
  assign gf.score         = score_q;
  assign gf.game_run      = game_run_q;
  assign gf.npc_respawn   = npc_respawn_q;
  assign gf.collision_clr = collision_clr_q;
  assign gf.crash_blink   = crash_blink_q;

endmodule
